// File: rtl/frame_commit_if.sv
// Frame-gating stream bundle: RMII-side aggregated words and verdict in, committed stream out.
interface frame_commit_if;
  logic        frame_active;
  logic        axiiv;
  logic [31:0] axiid;
  logic        done;
  logic        kill;
  logic        axiov;
  logic [31:0] axiod;
  logic        axiolast;
  logic        axioready;

  modport master (
    output frame_active, axiiv, axiid, done, kill, axioready,
    input  axiov, axiod, axiolast
  );

  modport slave (
    input  frame_active, axiiv, axiid, done, kill, axioready,
    output axiov, axiod, axiolast
  );
endinterface

// File: rtl/frame_commit.sv
// Buffers each received frame and releases it downstream only after a passing checksum verdict;
// failed, overflowed, timed-out or superseded frames are rewound out of the buffer.
module frame_commit #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LENQ    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  frame_commit_if.slave     bus,
  output logic [15:0]       ok_count_o,
  output logic [15:0]       drop_count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned QW = (LENQ > 1) ? $clog2(LENQ) : 1;
  localparam int unsigned CW = $clog2(LENQ + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StWait} state_e;
  state_e state_q, state_d;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_q, wrs_q, commit_q, rd_q, len_q;
  logic          ovf_q, fa_q;
  logic [TW-1:0] tmo_q;
  logic [PW-1:0] lenq_q [LENQ];
  logic [QW-1:0] qhead_q, qtail_q;
  logic [CW-1:0] qcnt_q;
  logic [15:0]   ok_q, drop_q;

  logic          rise, fall, wr_try, wr_en, ovf_now, verdict, commit, wait_idle;
  logic          restart, tmo_hit, drop, start, xfer, pop, avail;
  logic [PW-1:0] used, len_now, wr_now, wr_next, head_rem;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StRecv;
      StRecv: begin
        if (verdict)   state_d = start ? StRecv : StIdle;
        else if (fall) state_d = StWait;
      end
      StWait: begin
        if (verdict)      state_d = start ? StRecv : StIdle;
        else if (restart) state_d = StRecv;
        else if (tmo_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rise      = bus.frame_active & ~fa_q;
    fall      = ~bus.frame_active & fa_q;
    used      = wr_q - rd_q;
    wr_try    = (state_q == StRecv) & bus.axiiv;
    wr_en     = wr_try & (used < PW'(DEPTH));
    ovf_now   = ovf_q | (wr_try & ~wr_en);
    len_now   = len_q + PW'(wr_en);
    wr_now    = wr_q + PW'(wr_en);
    // The verdict sees the word written in the same cycle.
    verdict   = (state_q != StIdle) & bus.done;
    commit    = verdict & ~bus.kill & ~ovf_now & (len_now != '0) & (qcnt_q != CW'(LENQ));
    wait_idle = (state_q == StWait) & ~bus.done;
    restart   = wait_idle & rise;
    tmo_hit   = wait_idle & ~rise & (tmo_q == TW'(TIMEOUT - 1));
    drop      = (verdict & ~commit) | restart | tmo_hit;
    start     = rise & ((state_q == StIdle) | verdict | restart);
    wr_next   = drop ? wrs_q : wr_now;
  end

  // commit_q bounds reads so uncommitted words are never visible.
  always_comb begin
    avail         = (qcnt_q != '0) & (rd_q != commit_q);
    head_rem      = lenq_q[qhead_q];
    bus.axiov     = ~rst_i & avail;
    bus.axiod     = bus.axiov ? mem_q[rd_q[AW-1:0]] : 32'h0;
    bus.axiolast  = bus.axiov & (head_rem == PW'(1));
    xfer          = bus.axiov & bus.axioready;
    pop           = xfer & bus.axiolast;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= bus.axiid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fa_q     <= 1'b0;
      wr_q     <= '0;
      wrs_q    <= '0;
      commit_q <= '0;
      rd_q     <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= '0;
      ok_q     <= '0;
      drop_q   <= '0;
    end else begin
      fa_q  <= bus.frame_active;
      wr_q  <= wr_next;
      if (start) wrs_q <= wr_next;
      len_q <= start ? '0 : len_now;
      ovf_q <= start ? 1'b0 : ovf_now;
      tmo_q <= wait_idle ? tmo_q + TW'(1) : '0;
      if (commit) commit_q <= wr_now;
      rd_q  <= rd_q + PW'(xfer);
      if (commit) ok_q <= ok_q + 16'd1;
      if (drop)   drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(LENQ); i++) lenq_q[i] <= '0;
      qhead_q <= '0;
      qtail_q <= '0;
      qcnt_q  <= '0;
    end else begin
      if (commit) begin
        lenq_q[qtail_q] <= len_now;
        qtail_q <= (qtail_q == QW'(LENQ - 1)) ? '0 : qtail_q + QW'(1);
      end
      if (xfer && !pop) lenq_q[qhead_q] <= head_rem - PW'(1);
      if (pop) qhead_q <= (qhead_q == QW'(LENQ - 1)) ? '0 : qhead_q + QW'(1);
      if (commit && !pop)      qcnt_q <= qcnt_q + CW'(1);
      else if (!commit && pop) qcnt_q <= qcnt_q - CW'(1);
    end
  end

  assign ok_count_o   = ok_q;
  assign drop_count_o = drop_q;
endmodule

// File: tb/tb_frame_commit.sv
// Bench for frame_commit: directed frame scenarios plus randomized traffic against a
// queue-based frame-level reference model.
module tb_frame_commit;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LENQ    = 4;
  localparam int unsigned TIMEOUT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ok_count, drop_count;

  always #5 clk = ~clk;

  frame_commit_if bus_if ();

  frame_commit #(
    .DEPTH  (DEPTH),
    .LENQ   (LENQ),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus_if),
    .ok_count_o  (ok_count),
    .drop_count_o(drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 receiving, 2 awaiting verdict.
  int          m_state = 0;
  logic [31:0] cur [$];
  bit          m_ovf = 0;
  int          m_tmo = 0;
  logic [31:0] out_words [$];
  int          out_lens [$];
  bit          prev_fa = 0;
  logic [15:0] m_ok = 0;
  logic [15:0] m_drop = 0;
  logic [32:0] got [$];
  bit          rand_ready = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit fa, input bit iv, input logic [31:0] d, input bit dn,
                       input bit kl);
    bus_if.frame_active = fa;
    bus_if.axiiv        = iv;
    bus_if.axiid        = d;
    bus_if.done         = dn;
    bus_if.kill         = kl;
  endtask

  task automatic m_start();
    cur.delete();
    m_ovf   = 0;
    m_state = 1;
  endtask

  task automatic model_update();
    bit fa, rise, fall, xfer;
    int used;
    if (rst) begin
      m_state = 0; cur.delete(); m_ovf = 0; m_tmo = 0;
      out_words.delete(); out_lens.delete(); prev_fa = 0; m_ok = 0; m_drop = 0;
      return;
    end
    fa   = bus_if.frame_active;
    rise = fa && !prev_fa;
    fall = !fa && prev_fa;
    xfer = (out_lens.size() > 0) && bus_if.axioready;
    used = cur.size() + out_words.size();
    if (m_state == 0) begin
      if (rise) m_start();
    end else begin
      if (m_state == 1 && bus_if.axiiv) begin
        if (used < int'(DEPTH)) cur.push_back(bus_if.axiid);
        else m_ovf = 1;
      end
      if (bus_if.done) begin
        if (!bus_if.kill && !m_ovf && cur.size() > 0 && out_lens.size() < int'(LENQ)) begin
          foreach (cur[i]) out_words.push_back(cur[i]);
          out_lens.push_back(cur.size());
          m_ok++;
        end else m_drop++;
        cur.delete();
        if (rise) m_start();
        else m_state = 0;
      end else if (m_state == 1) begin
        if (fall) begin m_state = 2; m_tmo = 0; end
      end else if (rise) begin
        m_drop++;
        m_start();
      end else if (m_tmo == int'(TIMEOUT) - 1) begin
        m_drop++;
        cur.delete();
        m_state = 0;
      end else m_tmo++;
    end
    if (xfer) begin
      void'(out_words.pop_front());
      out_lens[0] = out_lens[0] - 1;
      if (out_lens[0] == 0) void'(out_lens.pop_front());
    end
    prev_fa = fa;
  endtask

  task automatic step();
    logic        ev, el;
    logic [31:0] ed;
    if (rand_ready) bus_if.axioready = ($urandom % 3) != 0;
    @(negedge clk);
    if (rst || out_lens.size() == 0) begin ev = 0; ed = 0; el = 0; end
    else begin ev = 1; ed = out_words[0]; el = (out_lens[0] == 1); end
    check_eq("axiov", {31'h0, bus_if.axiov}, {31'h0, ev});
    check_eq("axiod", bus_if.axiod, ed);
    check_eq("axiolast", {31'h0, bus_if.axiolast}, {31'h0, el});
    if (!rst) begin
      check_eq("ok_count", {16'h0, ok_count}, {16'h0, m_ok});
      check_eq("drop_count", {16'h0, drop_count}, {16'h0, m_drop});
    end
    if (bus_if.axiov && bus_if.axioready) got.push_back({bus_if.axiolast, bus_if.axiod});
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 32'h0, 0, 0);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0);
    step();
    step();
    rst = 1'b0;
    got.delete();
  endtask

  // Words are base*1, base*2, ...
  task automatic frame_words(input int n, input logic [31:0] base);
    drive(1, 0, 32'h0, 0, 0);
    step();
    for (int i = 0; i < n; i++) begin
      drive(1, 1, base * (i + 1), 0, 0);
      step();
    end
    drive(0, 0, 32'h0, 0, 0);
    step();
  endtask

  task automatic verdict(input bit kl);
    drive(0, 0, 32'h0, 1, kl);
    step();
    drive(0, 0, 32'h0, 0, 0);
  endtask

  task automatic rand_frame();
    int mode, n;
    mode = $urandom % 8;
    n    = ($urandom % 10 == 0) ? $urandom_range(40, 80) : $urandom_range(0, 12);
    if ($urandom % 60 == 0) begin
      rst = 1'b1; step(); rst = 1'b0;
    end
    drive(1, 0, 32'h0, 0, 0);
    step();
    for (int i = 0; i < n; i++) begin
      drive(1, ($urandom % 4) != 0, $urandom, (mode == 0) && (i == n - 1), ($urandom % 4) == 0);
      step();
    end
    if (mode == 3) drive(0, 0, 32'h0, 1, ($urandom % 4) == 0);
    else drive(0, 0, 32'h0, 0, 0);
    step();
    drive(0, 0, 32'h0, 0, 0);
    case (mode)
      0, 2, 3: ;
      1: idle(TIMEOUT + 1);
      4: begin
        idle($urandom_range(0, 3));
        drive(1, 0, 32'h0, 1, ($urandom % 4) == 0);
        step();
        for (int i = 0; i < 3; i++) begin
          drive(1, 1, $urandom, 0, 0);
          step();
        end
        drive(0, 0, 32'h0, 0, 0);
        step();
        verdict(0);
      end
      default: begin
        idle($urandom_range(0, 5));
        verdict(($urandom % 4) == 0);
        idle($urandom_range(0, 3));
      end
    endcase
  endtask

  initial begin
    drive(0, 0, 32'h0, 0, 0);
    bus_if.axioready = 1'b0;

    // Basic 3-word good frame.
    do_reset();
    bus_if.axioready = 1'b1;
    frame_words(3, 32'h11111111);
    verdict(0);
    idle(6);
    check_eq("f3_count", got.size(), 3);
    if (got.size() == 3) begin
      check_eq("f3_w0", got[0][31:0], 32'h11111111);
      check_eq("f3_l0", {31'h0, got[0][32]}, 0);
      check_eq("f3_w1", got[1][31:0], 32'h22222222);
      check_eq("f3_l1", {31'h0, got[1][32]}, 0);
      check_eq("f3_w2", got[2][31:0], 32'h33333333);
      check_eq("f3_l2", {31'h0, got[2][32]}, 1);
    end
    check_eq("f3_ok", {16'h0, ok_count}, 1);

    // Killed frame then a passing single word.
    do_reset();
    frame_words(2, 32'h5A5A5A5A);
    verdict(1);
    frame_words(1, 32'hAAAAAAAA);
    verdict(0);
    idle(4);
    check_eq("kill_count", got.size(), 1);
    if (got.size() == 1) check_eq("kill_word", got[0][31:0], 32'hAAAAAAAA);
    check_eq("kill_drop", {16'h0, drop_count}, 1);
    check_eq("kill_ok", {16'h0, ok_count}, 1);

    // Overflowing frame dropped; a full-depth frame afterwards proves the buffer emptied.
    do_reset();
    bus_if.axioready = 1'b0;
    frame_words(70, 32'h01010101);
    verdict(0);
    idle(3);
    check_eq("ovf_drop", {16'h0, drop_count}, 1);
    check_eq("ovf_ok", {16'h0, ok_count}, 0);
    bus_if.axioready = 1'b1;
    frame_words(int'(DEPTH), 32'h00000103);
    verdict(0);
    idle(int'(DEPTH) + 4);
    check_eq("full_count", got.size(), DEPTH);
    if (got.size() == DEPTH) check_eq("full_last", {31'h0, got[DEPTH-1][32]}, 1);

    // Length queue full: last frame dropped.
    do_reset();
    bus_if.axioready = 1'b0;
    for (int k = 0; k <= int'(LENQ); k++) begin
      frame_words(1, 32'hC0000000 + k);
      verdict(0);
    end
    check_eq("lq_ok", {16'h0, ok_count}, LENQ);
    check_eq("lq_drop", {16'h0, drop_count}, 1);
    bus_if.axioready = 1'b1;
    idle(int'(LENQ) + 4);
    check_eq("lq_count", got.size(), LENQ);
    foreach (got[k]) begin
      check_eq("lq_word", got[k][31:0], 32'hC0000000 + k);
      check_eq("lq_last", {31'h0, got[k][32]}, 1);
    end

    // Verdict timeout, then a good frame.
    do_reset();
    frame_words(2, 32'h0000F00D);
    idle(TIMEOUT + 2);
    check_eq("tmo_drop", {16'h0, drop_count}, 1);
    frame_words(1, 32'hBEEF0001);
    verdict(0);
    idle(4);
    check_eq("tmo_ok", {16'h0, ok_count}, 1);
    check_eq("tmo_count", got.size(), 1);
    if (got.size() == 1) check_eq("tmo_word", got[0][31:0], 32'hBEEF0001);

    // Reset during output of a 4-word frame.
    do_reset();
    bus_if.axioready = 1'b0;
    frame_words(4, 32'h01020304);
    verdict(0);
    bus_if.axioready = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_axiov", {31'h0, bus_if.axiov}, 0);
    check_eq("rst_ok", {16'h0, ok_count}, 0);
    check_eq("rst_drop", {16'h0, drop_count}, 0);
    idle(8);
    check_eq("rst_count", got.size(), 2);

    // Randomized traffic.
    do_reset();
    rand_ready = 1;
    repeat (250) rand_frame();
    rand_ready = 0;
    bus_if.axioready = 1'b1;
    idle(int'(DEPTH) + 16);
    check_eq("drained", {31'h0, bus_if.axiov}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_commit.md
FRAME_COMMIT -- requirements
Module: frame_commit

Interface
REQ-001: Parameter DEPTH, default 64, is the word buffer depth; it SHALL be a power of two and at least 4.
REQ-002: Parameter LENQ, default 4, is the number of committed-frame length entries held.
REQ-003: Parameter TIMEOUT, default 4096, is the clk cycles to wait for a checksum verdict after frame end.
REQ-004: clk  input  1  single clock, all logic on rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: frame_active  input  1  high while an RMII frame is being received (ether axiov level).
REQ-007: axiiv  input  1  aggregated word valid.
REQ-008: axiid  input  32  aggregated word.
REQ-009: done  input  1  one-cycle checksum verdict strobe.
REQ-010: kill  input  1  checksum failed; meaningful only when done=1.
REQ-011: axiov  output  1  committed word valid.
REQ-012: axiod  output  32  committed word.
REQ-013: axiolast  output  1  last word of the current committed frame.
REQ-014: axioready  input  1  downstream accepts the word.
REQ-015: ok_count  output  16  frames committed, wraps at 16 bits.
REQ-016: drop_count  output  16  frames discarded, wraps at 16 bits.

Function
REQ-017: The block SHALL gate each received frame so that its words reach the output only after done=1 with kill=0; otherwise all words of that frame are discarded.
REQ-018: States SHALL be IDLE, RECV and WAIT.
- wr_ptr, wr_start, commit_ptr and rd_ptr are log2(DEPTH)+1 bits wide.
- used = wr_ptr - rd_ptr, modulo.
REQ-019: IDLE -> RECV on a frame_active rising edge (frame_active=1, previous cycle 0).
- On entry: wr_start <= wr_ptr, frame_len <= 0, ovf <= 0.
REQ-020: RECV write rule for each cycle with axiiv=1:
- if used < DEPTH: write axiid at wr_ptr, increment wr_ptr and frame_len;
- else: set ovf, no write.
REQ-021: RECV -> WAIT on frame_active falling edge; a word with axiiv=1 in that same cycle SHALL still be written.
REQ-022: The verdict is evaluated in the cycle where done=1 in RECV or WAIT, including any word written that cycle.
- Commit when kill=0, ovf=0, frame_len>0 and the length queue is not full: push frame_len, commit_ptr <= new wr_ptr, ok_count++.
- Otherwise drop: wr_ptr <= wr_start, drop_count++.
- Next state is IDLE, or RECV if frame_active rises in the same cycle, which then starts a new frame from the post-verdict wr_ptr.
REQ-023: In WAIT, a frame_active rising edge without done SHALL drop the pending frame (drop_count++), rewind wr_ptr to wr_start and enter RECV for the new frame.
REQ-024: In WAIT, TIMEOUT cycles without done SHALL drop the frame and return to IDLE.
REQ-025: done=1 in IDLE SHALL be ignored.
REQ-026: axiov = 1 iff the length queue is non-empty.
- axiod = buffer[rd_ptr], zero-latency read.
- axiod = 0 when axiov = 0.
REQ-027: A transfer occurs on a cycle with axiov=1 and axioready=1.
- On each transfer rd_ptr increments and the head remaining count decrements.
- On the last word the queue entry pops.
REQ-028: axiolast = 1 iff axiov=1 and the head remaining count = 1.
REQ-029: While axiov=1 and axioready=0, axiod and axiolast SHALL hold stable.
REQ-030: A commit push and an output pop in the same cycle SHALL both take effect; the queue occupancy is unchanged.
REQ-031: Uncommitted words SHALL never be presented, i.e. rd_ptr never passes commit_ptr.
REQ-032: Pointers SHALL wrap modulo DEPTH for addressing; a frame may straddle the buffer end.

Reset
REQ-033: On rst=1 at a clk edge, state <= IDLE and all pointers, frame_len, ovf, the timeout counter, the length queue, ok_count and drop_count <= 0.
REQ-034: While rst=1 and on the following cycle, axiov=0, axiod=0 and axiolast=0.
REQ-035: rst mid-frame or mid-output SHALL discard all buffered and committed data without a counter update.
REQ-036: Buffer RAM contents need not be cleared.

Verification
REQ-037: 3-word frame 0x11111111, 0x22222222, 0x33333333, done=1, kill=0, axioready=1 -> three transfers in order, axiolast only on 0x33333333, ok_count=1.
REQ-038: 2-word frame, done=1, kill=1, then a 1-word frame 0xAAAAAAAA that passes -> only 0xAAAAAAAA is output, drop_count=1, ok_count=1.
REQ-039: DEPTH=64 with axioready=0 and a 70-word frame that passes checksum -> frame dropped, used returns to 0, axiov stays 0.
REQ-040: LENQ+1 one-word good frames with axioready=0 -> the first LENQ are committed and the last is dropped; then axioready=1 -> LENQ transfers, each with axiolast=1.
REQ-041: frame_active falls and no done arrives for TIMEOUT cycles -> drop_count=1, state IDLE, a following good frame is output correctly.
REQ-042: rst pulsed during the output of a committed 4-word frame after 2 transfers -> axiov=0 next cycle, counters 0, no remaining words are emitted.
